tt_um_suba: RTL and testbench

- TinyTapeout user macro implementing a byte-oriented SPI-style serial slave with loopback transmit.
- While chip-select is low, it samples MOSI MSB-first, one bit per clk rising edge, and assembles an 8-bit frame.
- At the same time it shifts the previously received byte out on MISO, and echoes a gated serial clock (SCLK).
- The last completed byte is presented on the bidirectional pins as outputs.

---
 rtl/tt_suba_pkg.sv | 21 ++
 rtl/suba_spi_core.sv | 102 ++++++++++
 rtl/tt_um_suba.sv | 48 ++++
 tb/tb_tt_um_suba.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/tt_suba_pkg.sv
// Shared constants and types for the tt_um_suba SPI-style loopback slave.
package tt_suba_pkg;

   localparam int unsigned FRAME_BITS = 8;
   localparam int unsigned CNT_W      = $clog2(FRAME_BITS);
   localparam logic [FRAME_BITS-1:0] RESET_BYTE = 8'h00;

   localparam int unsigned CS_IDX   = 0;
   localparam int unsigned MOSI_IDX = 1;
   localparam int unsigned BUSY_IDX = 1;
   localparam int unsigned DONE_IDX = 0;
   localparam int unsigned SCLK_IDX = 6;
   localparam int unsigned MISO_IDX = 7;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

endpackage

// File: rtl/suba_spi_core.sv
// Frame FSM, bit counter and rx/tx shift registers for the serial slave.
module suba_spi_core
   import tt_suba_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_cs,
   input  logic                  i_mosi,
   output logic                  o_miso,
   output logic                  o_sclk_c,
   output logic                  o_busy,
   output logic                  o_frame_done,
   output logic [FRAME_BITS-1:0] o_rx_last
);

   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

   state_e                r_state, w_state_nxt;
   logic [CNT_W-1:0]      r_bit_cnt, w_bit_cnt_nxt;
   logic [FRAME_BITS-1:0] r_rx_shift, w_rx_shift_nxt;
   logic [FRAME_BITS-1:0] r_tx_shift, w_tx_shift_nxt;
   logic [FRAME_BITS-1:0] r_rx_last, w_rx_last_nxt;
   logic                  r_frame_done, w_frame_done_nxt;
   logic                  r_miso, w_miso_nxt;
   logic                  r_busy, w_busy_nxt;
   logic [FRAME_BITS-1:0] w_rx_in;
   logic [FRAME_BITS-1:0] w_tx_out;

   assign w_rx_in  = {r_rx_shift[FRAME_BITS-2:0], i_mosi};
   assign w_tx_out = {r_tx_shift[FRAME_BITS-2:0], 1'b0};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_bit_cnt    <= '0;
         r_rx_shift   <= '0;
         r_tx_shift   <= RESET_BYTE;
         r_rx_last    <= RESET_BYTE;
         r_frame_done <= 1'b0;
         r_miso       <= RESET_BYTE[FRAME_BITS-1];
         r_busy       <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_bit_cnt    <= w_bit_cnt_nxt;
         r_rx_shift   <= w_rx_shift_nxt;
         r_tx_shift   <= w_tx_shift_nxt;
         r_rx_last    <= w_rx_last_nxt;
         r_frame_done <= w_frame_done_nxt;
         r_miso       <= w_miso_nxt;
         r_busy       <= w_busy_nxt;
      end
   end

   // cs high always wins, so a frame completing on the cs-rise edge is dropped
   always_comb begin
      w_state_nxt      = r_state;
      w_bit_cnt_nxt    = r_bit_cnt;
      w_rx_shift_nxt   = r_rx_shift;
      w_tx_shift_nxt   = r_tx_shift;
      w_rx_last_nxt    = r_rx_last;
      w_frame_done_nxt = 1'b0;
      if (i_cs) begin
         w_state_nxt    = IDLE;
         w_bit_cnt_nxt  = '0;
         w_tx_shift_nxt = r_rx_last;
      end else begin
         case (r_state)
            IDLE: begin
               w_rx_shift_nxt = w_rx_in;
               w_tx_shift_nxt = w_tx_out;
               w_bit_cnt_nxt  = CNT_W'(1);
               w_state_nxt    = SHIFT;
            end
            SHIFT: begin
               w_rx_shift_nxt = w_rx_in;
               w_tx_shift_nxt = w_tx_out;
               w_bit_cnt_nxt  = r_bit_cnt + CNT_W'(1);
               if (r_bit_cnt == LAST_BIT) begin
                  w_rx_last_nxt    = w_rx_in;
                  w_frame_done_nxt = 1'b1;
                  w_state_nxt      = DONE;
               end
            end
            DONE: begin
               w_state_nxt = DONE;
            end
            default: begin
               w_state_nxt = IDLE;
            end
         endcase
      end
      w_miso_nxt = (w_state_nxt != DONE) & w_tx_shift_nxt[FRAME_BITS-1];
      w_busy_nxt = (w_state_nxt == SHIFT);
   end

   assign o_sclk_c     = clk & ~i_cs & (r_state != DONE);
   assign o_miso       = r_miso;
   assign o_busy       = r_busy;
   assign o_frame_done = r_frame_done;
   assign o_rx_last    = r_rx_last;

endmodule

// File: rtl/tt_um_suba.sv
// TinyTapeout wrapper: maps TT pins onto the SPI loopback core.
module tt_um_suba
   import tt_suba_pkg::*;
(
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe,
   input  logic       ena,
   input  logic       clk,
   input  logic       rst_n
);

   logic                  w_miso;
   logic                  w_sclk;
   logic                  w_busy;
   logic                  w_frame_done;
   logic [FRAME_BITS-1:0] w_rx_last;
   logic                  w_unused;

   suba_spi_core u_core (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_cs         (ui_in[CS_IDX]),
      .i_mosi       (ui_in[MOSI_IDX]),
      .o_miso       (w_miso),
      .o_sclk_c     (w_sclk),
      .o_busy       (w_busy),
      .o_frame_done (w_frame_done),
      .o_rx_last    (w_rx_last)
   );

   always_comb begin
      uo_out           = '0;
      uo_out[MISO_IDX] = w_miso;
      uo_out[SCLK_IDX] = w_sclk;
      uo_out[BUSY_IDX] = w_busy;
      uo_out[DONE_IDX] = w_frame_done;
   end

   assign uio_out = w_rx_last;
   assign uio_oe  = 8'hFF;

   // board mirrors, enable and bidir inputs carry no function here
   assign w_unused = &{1'b0, ena, uio_in, ui_in[7:2]};

endmodule

// File: tb/tb_tt_um_suba.sv
// Table-driven and scoreboard bench for tt_um_suba.
module tb_tt_um_suba;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int checks;
   int failures;
   int done_seen;
   logic [7:0] sb_q[$];

   typedef struct {
      logic       cs;
      logic       mosi;
      logic       miso;
      logic       sclk;
      logic       busy;
      logic       done;
      logic [7:0] uio;
   } vec_t;

   vec_t vt[19];

   tt_um_suba dut (
      .ui_in   (ui_in),
      .uo_out  (uo_out),
      .uio_in  (uio_in),
      .uio_out (uio_out),
      .uio_oe  (uio_oe),
      .ena     (ena),
      .clk     (clk),
      .rst_n   (rst_n)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %02h want %02h", name, act, exp);
      end
   endtask

   // drive on the falling edge, sample 1 time unit after the rising edge
   task automatic cycle(input logic cs, input logic mosi);
      @(negedge clk);
      ui_in[0] = cs;
      ui_in[1] = mosi;
      @(posedge clk);
      #1;
      if (uo_out[0] === 1'b1) begin
         done_seen++;
         if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_pop: frame_done with empty queue, uio_out got %02h want none", uio_out);
         end else begin
            chk("sb_rx", uio_out, sb_q.pop_front());
         end
      end
   endtask

   function automatic logic [7:0] pins(input logic miso, input logic sclk,
                                       input logic busy, input logic done);
      return {miso, sclk, 4'b0000, busy, done};
   endfunction

   initial begin
      logic [7:0] b;
      checks    = 0;
      failures  = 0;
      done_seen = 0;
      ena       = 1'b1;
      uio_in    = 8'h00;
      ui_in     = 8'h01;
      rst_n     = 1'b1;

      // frame 1: 0xAC rx, transmits 0x00
      vt[0]  = '{0, 1, 0, 1, 1, 0, 8'h00};
      vt[1]  = '{0, 0, 0, 1, 1, 0, 8'h00};
      vt[2]  = '{0, 1, 0, 1, 1, 0, 8'h00};
      vt[3]  = '{0, 0, 0, 1, 1, 0, 8'h00};
      vt[4]  = '{0, 1, 0, 1, 1, 0, 8'h00};
      vt[5]  = '{0, 1, 0, 1, 1, 0, 8'h00};
      vt[6]  = '{0, 0, 0, 1, 1, 0, 8'h00};
      vt[7]  = '{0, 0, 0, 0, 0, 1, 8'hAC};
      vt[8]  = '{1, 0, 1, 0, 0, 0, 8'hAC};
      vt[9]  = '{1, 0, 1, 0, 0, 0, 8'hAC};
      // frame 2: 0x25 rx, transmits 0xAC
      vt[10] = '{0, 0, 0, 1, 1, 0, 8'hAC};
      vt[11] = '{0, 0, 1, 1, 1, 0, 8'hAC};
      vt[12] = '{0, 1, 0, 1, 1, 0, 8'hAC};
      vt[13] = '{0, 0, 1, 1, 1, 0, 8'hAC};
      vt[14] = '{0, 0, 1, 1, 1, 0, 8'hAC};
      vt[15] = '{0, 1, 0, 1, 1, 0, 8'hAC};
      vt[16] = '{0, 0, 0, 1, 1, 0, 8'hAC};
      vt[17] = '{0, 1, 0, 0, 0, 1, 8'h25};
      vt[18] = '{1, 0, 0, 0, 0, 0, 8'h25};

      // reset state
      #1 rst_n = 1'b0;
      #1;
      chk("rst_uo", uo_out, 8'h00);
      chk("rst_uio", uio_out, 8'h00);
      chk("rst_oe", uio_oe, 8'hFF);
      @(negedge clk);
      #2 rst_n = 1'b1;
      cycle(1'b1, 1'b0);
      chk("idle_uo", uo_out, 8'h00);
      chk("idle_uio", uio_out, 8'h00);

      // frames 1 and 2 with the cs gap between them
      for (int i = 0; i < 19; i++) begin
         if (i == 0)  sb_q.push_back(8'hAC);
         if (i == 10) sb_q.push_back(8'h25);
         cycle(vt[i].cs, vt[i].mosi);
         chk($sformatf("vec%0d_pins", i), uo_out,
             pins(vt[i].miso, vt[i].sclk, vt[i].busy, vt[i].done));
         chk($sformatf("vec%0d_uio", i), uio_out, vt[i].uio);
      end
      chk("done_cnt_f2", 8'(done_seen), 8'd2);

      // abort after four bits of 0x11
      cycle(1'b0, 1'b0);
      cycle(1'b0, 1'b0);
      cycle(1'b0, 1'b0);
      cycle(1'b0, 1'b1);
      chk("abort_busy", uo_out, pins(1'b0, 1'b1, 1'b1, 1'b0));
      cycle(1'b1, 1'b0);
      chk("abort_uo", uo_out, pins(1'b0, 1'b0, 1'b0, 1'b0));
      chk("abort_uio", uio_out, 8'h25);
      chk("abort_done_cnt", 8'(done_seen), 8'd2);

      // over-clock: 12 extra cs-low edges after a 0x88 frame
      b = 8'h88;
      sb_q.push_back(b);
      for (int k = 7; k >= 0; k--) cycle(1'b0, b[k]);
      chk("oc_uio", uio_out, 8'h88);
      for (int k = 0; k < 12; k++) begin
         cycle(1'b0, 1'($urandom_range(1, 0)));
         chk($sformatf("oc%0d_pins", k), uo_out, pins(1'b0, 1'b0, 1'b0, 1'b0));
      end
      chk("oc_uio_hold", uio_out, 8'h88);
      chk("oc_done_cnt", 8'(done_seen), 8'd3);

      // async reset pulse while bit 3 of a frame is pending
      cycle(1'b1, 1'b0);
      cycle(1'b0, 1'b1);
      cycle(1'b0, 1'b1);
      chk("pre_rst_busy", uo_out, pins(1'b0, 1'b1, 1'b1, 1'b0));
      chk("pre_rst_uio", uio_out, 8'h88);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_uo", uo_out, 8'h00);
      chk("mid_rst_uio", uio_out, 8'h00);
      chk("mid_rst_oe", uio_oe, 8'hFF);
      #1 rst_n = 1'b1;
      cycle(1'b1, 1'b0);
      chk("post_rst_uo", uo_out, 8'h00);
      chk("post_rst_uio", uio_out, 8'h00);

      chk("sb_empty", 8'(sb_q.size()), 8'd0);
      chk("done_total", 8'(done_seen), 8'd3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
